mcu_prog_loader: RTL and testbench

MCU_PROG_LOADER -- requirements
Module: mcu_prog_loader

---
 rtl/mcu_loader_pkg.sv | 17 +
 rtl/mcu_prog_loader_if.sv | 29 ++
 rtl/loader_timer.sv | 37 +++
 rtl/mcu_prog_loader.sv | 127 ++++++++++++
 tb/tb_mcu_prog_loader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_loader_pkg.sv
// Shared definitions for the MCU program loader: FSM state encoding, frame sync byte
// and the default inter-byte timeout (used when built with LOADER_TIMEOUT_EN).
package mcu_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  localparam int         TIMEOUT_CYC_DEF = 1000;

endpackage

// File: rtl/mcu_prog_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control status of the loader.
// Optional build macro LOADER_TIMEOUT_EN does not change this interface.
interface mcu_prog_loader_if #(
  parameter int ADDR_W = 8
);

  // A byte transfers in a cycle where rx_valid and rx_ready are both high at the rising
  // edge; rx_data must be stable while rx_valid is high, and there is no other qualifier.
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst_n;
  logic              load_done;
  logic              load_err;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, load_done, load_err
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, load_done, load_err
  );

endinterface

// File: rtl/loader_timer.sv
// Inter-byte watchdog: flags the TIMEOUT_CYC-th consecutive enabled cycle without a byte.
// Instantiated by mcu_prog_loader only when LOADER_TIMEOUT_EN is defined.
module loader_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q idle cycles have already elapsed; this one completes the budget.
  assign expired_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mcu_prog_loader.sv
// Frame-based program loader: A5 | N | N data bytes | sum, written to instruction memory
// while the core is held in reset. Define LOADER_TIMEOUT_EN to abort on inter-byte silence.
module mcu_prog_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = mcu_loader_pkg::TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  mcu_prog_loader_if.slave       bus,
  output mcu_loader_pkg::state_e state_o
);

  import mcu_loader_pkg::*;

  state_e            state_q, state_d;
  logic              ready_q;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              accept;
  logic              timeout_hit;

  assign accept = bus.rx_valid && ready_q;

`ifdef LOADER_TIMEOUT_EN
  loader_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .en_i     ((state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM)),
    .clr_i    (accept),
    .expired_o(timeout_hit)
  );
`else
  // TIMEOUT_CYC only has meaning in the timeout build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (accept && (bus.rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (bus.rx_data == 8'd0) begin
            state_d = ST_ERR;
          end else begin
            len_d   = bus.rx_data;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          wdata_d = bus.rx_data;
          addr_d  = ADDR_W'(cnt_q);
          cnt_d   = cnt_q + 8'd1;
          sum_d   = sum_q + bus.rx_data;
          if (cnt_q == len_q - 8'd1) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_d = (bus.rx_data == sum_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A byte arriving in the expiring cycle wins, since the timer is cleared by it.
    if (timeout_hit) begin
      state_d = ST_ERR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.rx_ready  = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rst_n = (state_q == ST_DONE);
  assign bus.load_done = (state_q == ST_DONE);
  assign bus.load_err  = (state_q == ST_ERR);
  assign state_o       = state_q;

endmodule

// File: tb/tb_mcu_prog_loader.sv
// Bench for mcu_prog_loader: directed frames plus randomized frames against a frame-level
// reference model; memory writes are scoreboarded through an expected queue.
module tb_mcu_prog_loader;

  import mcu_loader_pkg::*;

  logic   clk;
  logic   reset;
  state_e dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  frm[$];
  logic        exp_done;
  logic        exp_err;

  mcu_prog_loader_if #(.ADDR_W(8)) bus ();

  mcu_prog_loader #(
    .ADDR_W     (8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the oldest expected {addr, data}
  always @(negedge clk) begin
    if (reset && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(bus.mem_we), 32'd0);
      end else begin
        check("mem_write", {16'd0, bus.mem_addr, bus.mem_wdata}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // drivers
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int gap_max);
    foreach (frm[i]) begin
      send_byte(frm[i]);
      idle($urandom_range(0, gap_max));
    end
  endtask

  // reference model: interpret one complete frame from the frame-format rules
  task automatic model_frame();
    int         n;
    logic [7:0] s;
    n        = int'(frm[1]);
    s        = 8'd0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n == 0) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({8'(i), frm[2+i]});
        s = s + frm[2+i];
      end
      if (frm[2+n] == s) exp_done = 1'b1;
      else               exp_err  = 1'b1;
    end
  endtask

  task automatic build_random_frame(input int n, input bit good);
    logic [7:0] s;
    logic [7:0] d;
    s = 8'd0;
    frm.delete();
    frm.push_back(SYNC_BYTE);
    frm.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      d = ($urandom_range(0, 3) == 0) ? SYNC_BYTE : 8'($urandom_range(0, 255));
      frm.push_back(d);
      s = s + d;
    end
    if (good) frm.push_back(s);
    else      frm.push_back(s + 8'($urandom_range(1, 255)));
  endtask

  task automatic check_status(input string tag);
    idle(2);
    check({tag, "_done"},  32'(bus.load_done), 32'(exp_done));
    check({tag, "_err"},   32'(bus.load_err),  32'(exp_err));
    check({tag, "_cpurst"}, 32'(bus.cpu_rst_n), 32'(exp_done));
    check({tag, "_ready"}, 32'(bus.rx_ready),  32'd1);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.rx_ready),  32'd0);
    check({tag, "_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_cpurst"}, 32'(bus.cpu_rst_n), 32'd0);
    check({tag, "_done"},  32'(bus.load_done), 32'd0);
    check({tag, "_err"},   32'(bus.load_err),  32'd0);
    check({tag, "_state"}, 32'(dbg_state),     32'(ST_IDLE));
  endtask

  initial begin
    logic [7:0] j;
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    idle(3);
    check_reset_outputs("por");
    reset = 1'b1;
    idle(1);
    check("por_release_ready", 32'(bus.rx_ready), 32'd1);
    check("por_release_state", 32'(dbg_state), 32'(ST_IDLE));

    // junk before sync is ignored in IDLE
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle(1);
    check("junk_state", 32'(dbg_state), 32'(ST_IDLE));
    check("junk_cpurst", 32'(bus.cpu_rst_n), 32'd0);

    // good three-byte image
    frm = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
    model_frame();
    send_frame(0);
    check_status("good3");

    // bad checksum
    frm = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04};
    model_frame();
    send_frame(1);
    check_status("badsum");

    // zero length, then a minimal good frame
    frm = '{8'hA5, 8'h00};
    model_frame();
    send_frame(0);
    check_status("len0");
    frm = '{8'hA5, 8'h01, 8'h7F, 8'h7F};
    model_frame();
    send_frame(0);
    check_status("len1");

    // longest frame: addresses 0..254
    build_random_frame(255, 1'b1);
    model_frame();
    send_frame(0);
    check_status("len255");

    // reset in the middle of the data phase
    exp_q.push_back({8'd0, 8'hC3});
    exp_q.push_back({8'd1, 8'h3C});
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'hC3);
    send_byte(8'h3C);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    check("midrst_release_ready", 32'(bus.rx_ready), 32'd1);
    check("midrst_release_state", 32'(dbg_state), 32'(ST_IDLE));
    frm = '{8'hA5, 8'h02, 8'h0A, 8'h0B, 8'h15};
    model_frame();
    send_frame(0);
    check_status("after_rst");

    // silence in the middle of the data phase
    exp_q.push_back({8'd0, 8'h11});
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h11);
    idle(16);
`ifdef LOADER_TIMEOUT_EN
    check("timeout_state", 32'(dbg_state), 32'(ST_ERR));
    check("timeout_err", 32'(bus.load_err), 32'd1);
    check("timeout_cpurst", 32'(bus.cpu_rst_n), 32'd0);
`else
    check("notimeout_state", 32'(dbg_state), 32'(ST_DATA));
    check("notimeout_err", 32'(bus.load_err), 32'd0);
    exp_q.push_back({8'd1, 8'h22});
    exp_q.push_back({8'd2, 8'h33});
    exp_q.push_back({8'd3, 8'h44});
    exp_done = 1'b1;
    exp_err  = 1'b0;
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'hAA);
    check_status("notimeout_finish");
`endif

    // randomized frames with random junk and inter-byte gaps below the timeout
    for (int f = 0; f < 24; f++) begin
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom_range(0, 255));
        if (j == SYNC_BYTE) j = 8'h00;
        send_byte(j);
      end
      build_random_frame($urandom_range(1, 40), $urandom_range(0, 3) != 0);
      model_frame();
      send_frame(3);
      check_status($sformatf("rand%0d", f));
    end

    idle(2);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
